// File: rtl/alu_mdu_pipe.sv
// Execute-stage ALU with a registered valid/ready result stage and an iterative
// multiply/divide unit (shift-add multiply, restoring divide) that owns HI/LO.
module alu_mdu_pipe #(
  parameter int DATA_W     = 32,
  parameter bit ENABLE_MDU = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags,
  output logic              busy
);
  // state | meaning
  // IDLE  | no MDU op in flight; single-cycle ops may issue
  // RUN   | one multiply/divide iteration per cycle, cnt_q counts down
  // FIN   | sign fix applied; waits for a free output register

  localparam int LOG_W = $clog2(DATA_W);
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  state_t state_q, state_d;

  logic [5:0]        opcode, funct;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sext, imm_zext;
  logic [LOG_W-1:0]  sh_imm, sh_var;
  logic              unused_fields;

  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign shamt    = instruction[10:6];
  assign imm      = instruction[15:0];
  assign imm_sext = DATA_W'($signed(imm));
  assign imm_zext = DATA_W'(imm);
  // Cast truncates for narrow datapaths and zero-extends for wide ones: both equal shamt mod DATA_W.
  assign sh_imm   = LOG_W'(shamt);
  assign sh_var   = reg_a[LOG_W-1:0];
  assign unused_fields = ^instruction[25:11];

  logic [DATA_W-1:0] sum_rr, diff_rr, sum_ri;
  assign sum_rr  = reg_a + reg_b;
  assign diff_rr = reg_a - reg_b;
  assign sum_ri  = reg_a + imm_sext;

  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf, alu_neg, alu_zero;
  logic              is_mdu, mdu_signed, mdu_div;
  logic              lt_flag;
  logic [DATA_W-1:0] hi_q, lo_q;

  always_comb begin
    alu_res    = '0;
    alu_ovf    = 1'b0;
    alu_neg    = 1'b0;
    alu_zero   = 1'b0;
    is_mdu     = 1'b0;
    mdu_signed = 1'b0;
    mdu_div    = 1'b0;
    lt_flag    = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00: alu_res = reg_b << sh_imm;
          6'h02: alu_res = reg_b >> sh_imm;
          6'h03: alu_res = $signed(reg_b) >>> sh_imm;
          6'h04: alu_res = reg_b << sh_var;
          6'h06: alu_res = reg_b >> sh_var;
          6'h07: alu_res = $signed(reg_b) >>> sh_var;
          6'h10: if (ENABLE_MDU) alu_res = hi_q;
          6'h12: if (ENABLE_MDU) alu_res = lo_q;
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            if (ENABLE_MDU) begin
              is_mdu     = 1'b1;
              mdu_signed = !funct[0];
              mdu_div    = funct[1];
            end
          end
          6'h20: begin
            alu_res = sum_rr;
            alu_ovf = (reg_a[MSB] == reg_b[MSB]) && (sum_rr[MSB] != reg_a[MSB]);
          end
          6'h21: alu_res = sum_rr;
          6'h22: begin
            alu_res = diff_rr;
            alu_ovf = (reg_a[MSB] != reg_b[MSB]) && (diff_rr[MSB] != reg_a[MSB]);
          end
          6'h23: alu_res = diff_rr;
          6'h24: alu_res = reg_a & reg_b;
          6'h25: alu_res = reg_a | reg_b;
          6'h26: alu_res = reg_a ^ reg_b;
          6'h27: alu_res = ~(reg_a | reg_b);
          6'h2A: begin
            lt_flag = $signed(reg_a) < $signed(reg_b);
            alu_res = DATA_W'(lt_flag);
            alu_neg = lt_flag;
          end
          6'h2B: begin
            lt_flag = reg_a < reg_b;
            alu_res = DATA_W'(lt_flag);
            alu_neg = lt_flag;
          end
          default: ;
        endcase
      end
      6'h04, 6'h05: begin
        alu_res  = diff_rr;
        alu_zero = (reg_a == reg_b);
      end
      6'h08: begin
        alu_res = sum_ri;
        alu_ovf = (reg_a[MSB] == imm_sext[MSB]) && (sum_ri[MSB] != reg_a[MSB]);
      end
      6'h09: alu_res = sum_ri;
      6'h0A: begin
        lt_flag = $signed(reg_a) < $signed(imm_sext);
        alu_res = DATA_W'(lt_flag);
        alu_neg = lt_flag;
      end
      6'h0B: begin
        lt_flag = reg_a < imm_sext;
        alu_res = DATA_W'(lt_flag);
        alu_neg = lt_flag;
      end
      6'h0C: alu_res = reg_a & imm_zext;
      6'h0D: alu_res = reg_a | imm_zext;
      6'h0E: alu_res = reg_a ^ imm_zext;
      6'h23, 6'h2B: alu_res = sum_ri;
      default: ;
    endcase
  end

  logic out_valid_q, out_free, accept, start, load_alu, load_mdu;
  logic [DATA_W-1:0] result_q;
  logic [2:0]        flags_q;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign start     = accept && is_mdu;
  assign load_alu  = accept && !is_mdu;
  assign load_mdu  = (state_q == S_FIN) && out_free;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign busy      = (state_q != S_IDLE);

  // MDU datapath: acc_q is the product high half / partial remainder,
  // lo_sh_q the multiplier / dividend that shifts into the quotient.
  logic [LOG_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, lo_sh_q, opnd_q, a_orig_q;
  logic              div_q, div0_q, neg_lo_q, neg_hi_q;
  logic [DATA_W-1:0] mag_a, mag_b, acc_d, lo_sh_d, fin_hi, fin_lo;
  logic [DATA_W:0]   msum, rem_sh, trial;

  assign mag_a  = (mdu_signed && reg_a[MSB]) ? -reg_a : reg_a;
  assign mag_b  = (mdu_signed && reg_b[MSB]) ? -reg_b : reg_b;
  assign msum   = {1'b0, acc_q} + (lo_sh_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_sh = {acc_q, lo_sh_q[MSB]};
  assign trial  = rem_sh - {1'b0, opnd_q};

  always_comb begin
    acc_d   = msum[DATA_W:1];
    lo_sh_d = {msum[0], lo_sh_q[MSB:1]};
    if (div_q) begin
      if (!trial[DATA_W]) begin
        acc_d   = trial[MSB:0];
        lo_sh_d = {lo_sh_q[MSB-1:0], 1'b1};
      end else begin
        acc_d   = rem_sh[MSB:0];
        lo_sh_d = {lo_sh_q[MSB-1:0], 1'b0};
      end
    end
  end

  always_comb begin
    fin_hi = acc_q;
    fin_lo = lo_sh_q;
    if (!div_q) begin
      if (neg_lo_q) {fin_hi, fin_lo} = -{acc_q, lo_sh_q};
    end else if (div0_q) begin
      fin_hi = a_orig_q;
      fin_lo = '1;
    end else begin
      if (neg_lo_q) fin_lo = -lo_sh_q;
      if (neg_hi_q) fin_hi = -acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIN;
      S_FIN:   if (out_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_sh_q     <= '0;
      opnd_q      <= '0;
      a_orig_q    <= '0;
      div_q       <= 1'b0;
      div0_q      <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
    end else begin
      if (load_alu) begin
        result_q <= alu_res;
        flags_q  <= {alu_zero, alu_neg, alu_ovf};
      end else if (load_mdu) begin
        result_q <= fin_lo;
        flags_q  <= '0;
      end
      if (load_alu || load_mdu) out_valid_q <= 1'b1;
      else if (out_ready)       out_valid_q <= 1'b0;
      if (load_mdu) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
      if (start) begin
        cnt_q    <= LOG_W'(DATA_W - 1);
        acc_q    <= '0;
        lo_sh_q  <= mag_a;
        opnd_q   <= mag_b;
        a_orig_q <= reg_a;
        div_q    <= mdu_div;
        div0_q   <= (reg_b == '0);
        neg_lo_q <= mdu_signed && (reg_a[MSB] ^ reg_b[MSB]);
        neg_hi_q <= mdu_signed && (mdu_div ? reg_a[MSB] : (reg_a[MSB] ^ reg_b[MSB]));
      end else if (state_q == S_RUN) begin
        acc_q   <= acc_d;
        lo_sh_q <= lo_sh_d;
        cnt_q   <= cnt_q - LOG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Directed bench for alu_mdu_pipe: a 32-bit MDU-enabled instance and a 64-bit MDU-less one,
// with expected beats queued at issue and compared as the output stage hands them over.
module tb_alu_mdu_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid32, in_valid64, in_ready32, in_ready64;
  logic [31:0] instruction;
  logic [63:0] reg_a, reg_b;
  logic        out_ready;
  logic        out_valid32, out_valid64;
  logic [31:0] result32;
  logic [63:0] result64;
  logic [2:0]  flags32, flags64;
  logic        busy32, busy64;

  typedef struct packed {
    logic [63:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   n;

  alu_mdu_pipe #(.DATA_W(32), .ENABLE_MDU(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .instruction(instruction), .reg_a(reg_a[31:0]), .reg_b(reg_b[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .result(result32),
    .flags(flags32), .busy(busy32)
  );

  alu_mdu_pipe #(.DATA_W(64), .ENABLE_MDU(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .instruction(instruction), .reg_a(reg_a), .reg_b(reg_b),
    .out_valid(out_valid64), .out_ready(out_ready), .result(result64),
    .flags(flags64), .busy(busy64)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  task automatic issue(input bit w64, input logic [31:0] ins, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_r,
                       input logic [2:0] exp_f, input bit push = 1'b1);
    int k;
    k = 0;
    #1;
    while (!(w64 ? in_ready64 : in_ready32) && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 200) begin
      check("issue_ready_timeout", 64'(w64 ? in_ready64 : in_ready32), 64'd1);
    end else begin
      instruction = ins;
      reg_a       = a;
      reg_b       = b;
      if (w64) in_valid64 = 1'b1;
      else     in_valid32 = 1'b1;
      if (push) begin
        if (w64) q64.push_back({exp_r, exp_f});
        else     q32.push_back({exp_r, exp_f});
      end
      @(negedge clk);
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
    end
  endtask

  // Output monitor: a beat is taken when out_valid && out_ready hold going into the next edge.
  always @(negedge clk) begin
    #1;
    if (out_valid32 && out_ready) begin
      check("sb32_pending", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e32 = q32.pop_front();
        check("sb32_result", 64'(result32), e32.res);
        check("sb32_flags", 64'(flags32), 64'(e32.flg));
      end
    end
    if (out_valid64 && out_ready) begin
      check("sb64_pending", 64'(q64.size() != 0), 64'd1);
      if (q64.size() != 0) begin
        e64 = q64.pop_front();
        check("sb64_result", result64, e64.res);
        check("sb64_flags", 64'(flags64), 64'(e64.flg));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    in_valid32  = 1'b0;
    in_valid64  = 1'b0;
    instruction = '0;
    reg_a       = '0;
    reg_b       = '0;
    out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_result", 64'(result32), 64'd0);
    check("rst_flags", 64'(flags32), 64'd0);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    check("rst64_result", result64, 64'd0);

    // Single-cycle ops, back to back
    issue(0, rtype(6'h20, 0), 64'h7FFFFFFF, 64'h1, 64'h80000000, 3'b001);
    issue(0, rtype(6'h21, 0), 64'h1, 64'h2, 64'h3, 3'b000);
    issue(0, rtype(6'h22, 0), 64'h80000000, 64'h1, 64'h7FFFFFFF, 3'b001);
    issue(0, rtype(6'h23, 0), 64'h5, 64'h7, 64'hFFFFFFFE, 3'b000);
    issue(0, rtype(6'h24, 0), 64'hF0F0, 64'hFF00, 64'hF000, 3'b000);
    issue(0, rtype(6'h25, 0), 64'hF0F0, 64'hFF00, 64'hFFF0, 3'b000);
    issue(0, rtype(6'h26, 0), 64'hF0F0, 64'hFF00, 64'h0FF0, 3'b000);
    issue(0, rtype(6'h27, 0), 64'h0, 64'h0, 64'hFFFFFFFF, 3'b000);
    issue(0, rtype(6'h2A, 0), 64'h1, 64'hFFFFFFFF, 64'h0, 3'b000);
    issue(0, rtype(6'h2B, 0), 64'h1, 64'hFFFFFFFF, 64'h1, 3'b010);
    issue(0, itype(6'h0A, 16'h0001), 64'hFFFFFFFE, 64'h0, 64'h1, 3'b010);
    issue(0, itype(6'h0B, 16'hFFFF), 64'h5, 64'h0, 64'h1, 3'b010);
    issue(0, itype(6'h0C, 16'h8000), 64'hFFFFFFFF, 64'h0, 64'h00008000, 3'b000);
    issue(0, itype(6'h0D, 16'hFFFF), 64'h0, 64'h0, 64'h0000FFFF, 3'b000);
    issue(0, itype(6'h0E, 16'h00FF), 64'hFFFFFFFF, 64'h0, 64'hFFFFFF00, 3'b000);
    issue(0, itype(6'h08, 16'h0001), 64'h7FFFFFFF, 64'h0, 64'h80000000, 3'b001);
    issue(0, itype(6'h09, 16'hFFFF), 64'h0, 64'h0, 64'hFFFFFFFF, 3'b000);
    issue(0, itype(6'h23, 16'hFFFC), 64'h1000, 64'h0, 64'h0FFC, 3'b000);
    issue(0, itype(6'h2B, 16'h0004), 64'h1000, 64'h0, 64'h1004, 3'b000);
    issue(0, itype(6'h04, 16'h0010), 64'h5, 64'h5, 64'h0, 3'b100);
    issue(0, itype(6'h05, 16'h0010), 64'h5, 64'h3, 64'h2, 3'b000);
    issue(0, rtype(6'h00, 5'd31), 64'h0, 64'h1, 64'h80000000, 3'b000);
    issue(0, rtype(6'h02, 5'd4), 64'h0, 64'h80000000, 64'h08000000, 3'b000);
    issue(0, rtype(6'h03, 5'd4), 64'h0, 64'h80000000, 64'hF8000000, 3'b000);
    issue(0, rtype(6'h04, 0), 64'd33, 64'h1, 64'h2, 3'b000);
    issue(0, rtype(6'h06, 0), 64'd36, 64'hF0, 64'h0F, 3'b000);
    issue(0, rtype(6'h07, 0), 64'd1, 64'h80000000, 64'hC0000000, 3'b000);
    issue(0, itype(6'h3F, 16'h1234), 64'h5, 64'h5, 64'h0, 3'b000);
    issue(0, rtype(6'h3F, 0), 64'h5, 64'h5, 64'h0, 3'b000);

    // Output stall: result held, in_ready low, then exactly one beat
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    issue(0, rtype(6'h20, 0), 64'h7FFFFFFF, 64'h1, 64'h80000000, 3'b001);
    repeat (3) begin
      #1;
      check("stall_out_valid", 64'(out_valid32), 64'd1);
      check("stall_result", 64'(result32), 64'h80000000);
      check("stall_in_ready", 64'(in_ready32), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("stall_single_beat", 64'(out_valid32), 64'd0);

    // MDU: latency of a signed multiply, then HI/LO readback
    issue(0, rtype(6'h18, 0), 64'hFFFFFFFF, 64'h2, 64'hFFFFFFFE, 3'b000);
    #1;
    check("mult_busy", 64'(busy32), 64'd1);
    check("mult_in_ready", 64'(in_ready32), 64'd0);
    n = 0;
    while (!out_valid32 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mult_latency", 64'(n), 64'd33);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'hFFFFFFFF, 3'b000);
    issue(0, rtype(6'h12, 0), 64'h0, 64'h0, 64'hFFFFFFFE, 3'b000);
    issue(0, rtype(6'h19, 0), 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 3'b000);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'hFFFFFFFE, 3'b000);
    issue(0, rtype(6'h1B, 0), 64'h7, 64'h0, 64'hFFFFFFFF, 3'b000);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'h7, 3'b000);
    issue(0, rtype(6'h1A, 0), 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 3'b000);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'hFFFFFFFF, 3'b000);
    issue(0, rtype(6'h1A, 0), 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 3'b000);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'h0, 3'b000);
    issue(0, rtype(6'h1A, 0), 64'h7, 64'hFFFFFFFE, 64'hFFFFFFFD, 3'b000);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'h1, 3'b000);
    issue(0, rtype(6'h1A, 0), 64'hFFFFFFF9, 64'h0, 64'hFFFFFFFF, 3'b000);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'hFFFFFFF9, 3'b000);
    issue(0, rtype(6'h1B, 0), 64'd100, 64'd7, 64'd14, 3'b000);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'd2, 3'b000);

    // Reset in the middle of a divide abandons it and clears HI/LO
    issue(0, rtype(6'h1B, 0), 64'd100, 64'd7, 64'd0, 3'b000, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid32), 64'd0);
    check("midrst_result", 64'(result32), 64'd0);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_in_ready", 64'(in_ready32), 64'd1);
    issue(0, rtype(6'h10, 0), 64'h0, 64'h0, 64'h0, 3'b000);
    issue(0, rtype(6'h12, 0), 64'h0, 64'h0, 64'h0, 3'b000);

    // 64-bit datapath without MDU
    issue(1, rtype(6'h21, 0), 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 3'b000);
    issue(1, rtype(6'h20, 0), 64'h7FFFFFFFFFFFFFFF, 64'h1, 64'h8000000000000000, 3'b001);
    issue(1, rtype(6'h18, 0), 64'h3, 64'h5, 64'h0, 3'b000);
    #1;
    check("nomdu_busy", 64'(busy64), 64'd0);
    @(negedge clk);
    #1;
    check("nomdu_busy_later", 64'(busy64), 64'd0);
    issue(1, rtype(6'h10, 0), 64'h0, 64'h0, 64'h0, 3'b000);
    issue(1, rtype(6'h03, 5'd4), 64'h0, 64'h8000000000000000, 64'hF800000000000000, 3'b000);
    issue(1, rtype(6'h06, 0), 64'd68, 64'hF0, 64'h0F, 3'b000);
    issue(1, rtype(6'h00, 5'd31), 64'h0, 64'h1, 64'h0000000080000000, 3'b000);

    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("sb32_drained", 64'(q32.size()), 64'd0);
    check("sb64_drained", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_mdu_pipe.md
Name: alu_mdu_pipe

Overview:
- Parametrised, handshaked successor to the combinational execute-stage ALU.
- Decodes a 32-bit MIPS instruction, executes the ALU op on DATA_W-bit operands and registers the result behind a valid/ready output stage.
- Adds an iterative multiply/divide unit (mult, multu, div, divu) with HI/LO registers and mfhi/mflo.
- Sits in the EX stage; the pipeline stalls on in_ready.

Parameters:
- DATA_W, 32: operand/result width; power of two, at least 8.
- ENABLE_MDU, 1: when 0, mult/div/mfhi/mflo decode as unknown ops.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  block accepts the op this cycle.
- instruction  in  32  MIPS instruction word.
- reg_a  in  DATA_W  rs operand value.
- reg_b  in  DATA_W  rt operand value.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  DATA_W  registered result.
- flags  out  3  [2] zero, [1] negative, [0] overflow; registered with result.
- busy  out  1  MDU FSM not in IDLE.

Behaviour:
- Reset, when rst_n is low at an edge: out_valid=0, result=0, flags=000, HI=LO=0, FSM=IDLE, busy=0. A reset during a multi-cycle op abandons it; HI/LO are not updated.
- Handshake:
  - An op is accepted when in_valid && in_ready.
  - in_ready = (FSM==IDLE) && (!out_valid || out_ready).
  - result and flags hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads in the same edge.
- Single-cycle ops: result and flags are loaded at the accept edge, so out_valid is high in the next cycle. Back-to-back issue at one op per cycle is supported when out_ready=1.
- Operand rules:
  - imm is sign-extended to DATA_W for addi, addiu, slti, sltiu, lw, sw, beq, bne.
  - imm is zero-extended for andi, ori, xori.
  - Arithmetic wraps modulo 2^DATA_W.
- Ops:
  - add/addu/addi/addiu: sum.
  - sub/subu: reg_a - reg_b.
  - and/or/xor/nor/andi/ori/xori: bitwise.
  - slt/slti: signed compare; sltu/sltiu: unsigned compare. Result is 1 or 0.
  - lw/sw: reg_a + sext(imm).
  - beq/bne: reg_a - reg_b.
  - sll/srl/sra: reg_b shifted by shamt mod DATA_W.
  - sllv/srlv/srav: reg_b shifted by reg_a[log2(DATA_W)-1:0].
  - sra/srav: arithmetic shift.
- Flags (all other ops give 0):
  - overflow: add, addi, sub only; signed overflow of the DATA_W result.
  - negative: slt, slti, sltu, sltiu only; set when the compare is true.
  - zero: beq, bne only; set when reg_a == reg_b.
- Unknown opcode/funct: result=0, flags=000; still produces one output beat.
- MDU ops (funct 011000 mult, 011001 multu, 011010 div, 011011 divu):
  - FSM IDLE -> RUN on accept. Signed ops capture operand magnitudes and the result signs.
  - RUN: DATA_W iterations, one per cycle; shift-add multiply, restoring divide.
  - RUN -> FIN after the DATA_W-th iteration.
  - FIN: apply sign fix. HI/LO and the output register load on the first FIN cycle where (!out_valid || out_ready); then -> IDLE.
  - Latency with a free output: out_valid rises DATA_W+1 cycles after the accept edge.
  - The output beat carries result=LO, flags=000.
- MDU results:
  - mult/multu: {HI,LO} = 2*DATA_W-bit product.
  - div/divu: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero (signed or unsigned): LO = all ones, HI = reg_a.
  - div of MIN by -1: LO = MIN, HI = 0.
- mfhi (010000) / mflo (010010): single-cycle, result = HI/LO. These cannot issue while busy, because in_ready is low.
- busy is high in RUN and FIN.

Test Plan:
- Reset: drive rst_n=0 for 2 edges mid-div -> out_valid=0, result=0, busy=0, in_ready=1 after release, and a following mfhi returns 0.
- Handshake: add with reg_a=0x7FFFFFFF, reg_b=1, out_ready=1 -> next cycle result=0x80000000, flags=001. Repeat with out_ready=0 for 3 cycles -> result held, in_ready=0, then one beat on release.
- Decode/flags:
  - slti reg_a=0xFFFFFFFE, imm=0x0001 -> result=1, flags=010.
  - sltiu reg_a=5, imm=0xFFFF -> result=1.
  - andi imm=0x8000 -> zero-extended.
  - beq with equal operands -> flags=100.
- Shifts: sra reg_b=0x80000000, shamt=4 -> 0xF8000000. srlv reg_a=36, reg_b=0xF0 with DATA_W=32 -> 0x0F.
- MDU:
  - mult 0xFFFFFFFF x 2 (signed) -> out_valid after 33 cycles, LO=0xFFFFFFFE; mfhi -> 0xFFFFFFFF.
  - divu 7/0 -> LO=0xFFFFFFFF, HI=7.
  - div -7/2 -> LO=-3, HI=-1.
- DATA_W=64, ENABLE_MDU=0: addu wraps 0xFFFFFFFFFFFFFFFF+1 -> 0, flags=000. mult funct -> result=0 as an unknown op, busy stays 0.
